// File: rtl/load_unit.sv
// rtl/load_unit.sv - load unit: alignment/privilege checks, store forwarding, memory wait, byte/half extraction
//
// Optional feature macro: LOAD_FORWARD_EN (store-to-load forwarding; undefined = every legal load goes to memory)
//
// Ports:
//   clk_i, rst_n_i                  clock, asynchronous active-low reset
//   flush_i                         synchronous flush, returns to IDLE and drops any result
//   privilege_i                     1 = machine privilege (may touch private region)
//   valid_operation_i, load_address_i, operation_i
//                                   new load, sampled only in IDLE
//   wait_i                          downstream stall, holds the result in DONE
//   load_request_o, load_address_o  one-cycle word-aligned request to memory
//   load_valid_i, load_data_i       memory response, honoured only in WAIT_MEMORY
//   foward_address_o, foward_data_i, foward_match_i
//                                   store-unit forwarding lookup
//   loaded_data_o                   registered, extracted and extended result
//   data_valid_o, idle_o, illegal_access_o, misaligned_o
//                                   status flags
module load_unit #(
  parameter int unsigned BUS_TIMEOUT          = 255,
  parameter logic [31:0] PRIVATE_REGION_START = 32'hF000_0000,
  parameter logic [31:0] PRIVATE_REGION_END   = 32'hFFFE_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        privilege_i,
  input  logic        valid_operation_i,
  input  logic [31:0] load_address_i,
  input  logic [2:0]  operation_i,
  input  logic        wait_i,
  output logic        load_request_o,
  output logic [31:0] load_address_o,
  input  logic        load_valid_i,
  input  logic [31:0] load_data_i,
  output logic [29:0] foward_address_o,
  input  logic [31:0] foward_data_i,
  input  logic        foward_match_i,
  output logic [31:0] loaded_data_o,
  output logic        data_valid_o,
  output logic        idle_o,
  output logic        illegal_access_o,
  output logic        misaligned_o
);

  localparam int CW = $clog2(BUS_TIMEOUT + 1);

  localparam logic [2:0] LDB  = 3'd0;
  localparam logic [2:0] LDBU = 3'd1;
  localparam logic [2:0] LDH  = 3'd2;
  localparam logic [2:0] LDHU = 3'd3;
  localparam logic [2:0] LDW  = 3'd4;

  typedef enum logic [1:0] {IDLE, WAIT_MEMORY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   addr_q, addr_d;
  logic [2:0]    op_q, op_d;
  logic          ill_q, ill_d;
  logic          mis_q, mis_d;

  logic misaligned, illegal, fwd_hit;

  // Undefined opcodes fall through to word semantics.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [2:0] op,
                                          input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (op)
      LDB:     extract = {{24{b[7]}}, b};
      LDBU:    extract = {24'd0, b};
      LDH:     extract = {{16{h[15]}}, h};
      LDHU:    extract = {16'd0, h};
      default: extract = word;
    endcase
  endfunction

  assign misaligned = ((operation_i == LDH || operation_i == LDHU) && load_address_i[0]) ||
                      (operation_i == LDW && load_address_i[1:0] != 2'b00);
  assign illegal    = (load_address_i >= PRIVATE_REGION_START) &&
                      (load_address_i <= PRIVATE_REGION_END) && !privilege_i;

`ifdef LOAD_FORWARD_EN
  assign fwd_hit          = foward_match_i;
  assign foward_address_o = load_address_i[31:2];
`else
  logic unused_fwd;
  assign unused_fwd       = ^{foward_data_i, foward_match_i};
  assign fwd_hit          = 1'b0;
  assign foward_address_o = 30'd0;
`endif

  // In IDLE the request goes out the same cycle the op is accepted, so the address
  // comes straight from the input; afterwards the captured address is shown.
  assign load_address_o   = (state_q == IDLE) ? {load_address_i[31:2], 2'b00}
                                              : {addr_q[31:2], 2'b00};
  assign loaded_data_o    = data_q;
  assign illegal_access_o = ill_q;
  assign misaligned_o     = mis_q;
  assign data_valid_o     = (state_q == DONE);
  assign idle_o           = (state_q == IDLE);

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    data_d         = data_q;
    addr_d         = addr_q;
    op_d           = op_q;
    ill_d          = ill_q;
    mis_d          = mis_q;
    load_request_o = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      count_d = '0;
      data_d  = '0;
      ill_d   = 1'b0;
      mis_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_operation_i) begin
            addr_d  = load_address_i;
            op_d    = operation_i;
            count_d = '0;
            ill_d   = illegal;
            mis_d   = misaligned;
            data_d  = '0;
            if (misaligned || illegal) begin
              state_d = DONE;
            end else if (fwd_hit) begin
              data_d  = extract(foward_data_i, operation_i, load_address_i[1:0]);
              state_d = DONE;
            end else begin
              load_request_o = 1'b1;
              state_d        = WAIT_MEMORY;
            end
          end
        end
        WAIT_MEMORY: begin
          // A response in the final timeout cycle still wins over the abort.
          if (load_valid_i) begin
            data_d  = extract(load_data_i, op_q, addr_q[1:0]);
            count_d = '0;
            state_d = DONE;
          end else if (count_q == CW'(BUS_TIMEOUT - 1)) begin
            ill_d   = 1'b1;
            data_d  = '0;
            count_d = '0;
            state_d = DONE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
        DONE: begin
          if (!wait_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      count_q <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      op_q    <= '0;
      ill_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - randomized self-checking bench for load_unit against a behavioural model
module tb_load_unit;

  localparam logic [31:0] PS = 32'hF000_0000;
  localparam logic [31:0] PE = 32'hFFFE_FFFF;
`ifdef LOAD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0, priv = 1'b0, valid_op = 1'b0, wait_in = 1'b0;
  logic [31:0] addr_in = '0;
  logic [2:0]  op_in = '0;
  logic        load_valid = 1'b0, fmatch = 1'b0;
  logic [31:0] load_data = '0, fdata = '0;
  logic        load_request, data_valid, idle, illegal_access, misaligned;
  logic [31:0] load_address, loaded_data;
  logic [29:0] foward_address;

  int n_checks = 0;
  int n_pass   = 0;

  load_unit #(.BUS_TIMEOUT(255), .PRIVATE_REGION_START(PS), .PRIVATE_REGION_END(PE)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .privilege_i(priv),
    .valid_operation_i(valid_op), .load_address_i(addr_in), .operation_i(op_in),
    .wait_i(wait_in), .load_request_o(load_request), .load_address_o(load_address),
    .load_valid_i(load_valid), .load_data_i(load_data), .foward_address_o(foward_address),
    .foward_data_i(fdata), .foward_match_i(fmatch), .loaded_data_o(loaded_data),
    .data_valid_o(data_valid), .idle_o(idle), .illegal_access_o(illegal_access),
    .misaligned_o(misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference extraction from plain shifts and masks.
  function automatic logic [31:0] ref_extract(input int op, input int off, input logic [31:0] w);
    longint unsigned v;
    v = 64'(w);
    case (op)
      0: begin v = (v >> (8 * off)) & 255;   if (v >= 128)   v = v + 64'hFFFF_FF00; end
      1: v = (v >> (8 * off)) & 255;
      2: begin v = (v >> (16 * (off / 2))) & 65535; if (v >= 32768) v = v + 64'hFFFF_0000; end
      3: v = (v >> (16 * (off / 2))) & 65535;
      default: ;
    endcase
    return v[31:0];
  endfunction

  // lat = 0 means memory never answers (bus timeout).
  task automatic do_load(input int op, input logic [31:0] a, input bit pv, input int lat,
                         input logic [31:0] word, input bit match, input logic [31:0] fw,
                         input int wt);
    bit mis, ill, hit, fault;
    logic [31:0] exp_data;
    bit exp_ill;
    mis   = ((op == 2 || op == 3) && (a % 2 == 1)) || (op == 4 && (a % 4 != 0));
    ill   = (a >= PS) && (a <= PE) && !pv;
    fault = mis || ill;
    hit   = match && FWD;
    valid_op = 1'b1; op_in = 3'(op); addr_in = a; priv = pv; fmatch = match; fdata = fw;
    #1;
    check("idle_before", 32'(idle), 32'd1);
    check("request", 32'(load_request), (fault || hit) ? 32'd0 : 32'd1);
    if (!(fault || hit)) check("req_addr", load_address, a & 32'hFFFF_FFFC);
    check("fwd_addr", 32'(foward_address), FWD ? (a >> 2) : 32'd0);
    step();
    valid_op = 1'b0; fmatch = 1'b0;
    addr_in = $urandom; op_in = 3'($urandom_range(0, 4)); fdata = $urandom;
    exp_ill  = ill;
    exp_data = 32'd0;
    if (fault) begin
      exp_data = 32'd0;
    end else if (hit) begin
      exp_data = ref_extract(op, int'(a % 4), fw);
    end else begin
      check("wait_dv", 32'(data_valid), 32'd0);
      check("wait_req", 32'(load_request), 32'd0);
      if (lat == 0) begin
        repeat (254) step();
        check("pre_timeout_dv", 32'(data_valid), 32'd0);
        step();
        exp_ill = 1'b1;
      end else begin
        repeat (lat - 1) step();
        check("pre_resp_dv", 32'(data_valid), 32'd0);
        load_valid = 1'b1; load_data = word;
        step();
        load_valid = 1'b0; load_data = $urandom;
        exp_data = ref_extract(op, int'(a % 4), word);
      end
    end
    check("dv", 32'(data_valid), 32'd1);
    check("data", loaded_data, exp_data);
    check("illegal", 32'(illegal_access), 32'(exp_ill));
    check("misaligned", 32'(misaligned), 32'(mis));
    check("idle_done", 32'(idle), 32'd0);
    wait_in = (wt > 0);
    for (int i = 0; i < wt; i++) begin
      step();
      check("hold_dv", 32'(data_valid), 32'd1);
      check("hold_data", loaded_data, exp_data);
    end
    wait_in = 1'b0;
    step();
    check("back_idle", 32'(idle), 32'd1);
    check("dv_clear", 32'(data_valid), 32'd0);
  endtask

  initial begin
    #2;
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_data", loaded_data, 32'd0);
    check("rst_req", 32'(load_request), 32'd0);
    check("rst_flags", {30'd0, illegal_access, misaligned}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    do_load(4, 32'h1000, 1'b0, 3, 32'hDEADBEEF, 1'b0, 32'h0, 0);
    do_load(0, 32'h1003, 1'b0, 2, 32'h80FF1234, 1'b0, 32'h0, 0);
    do_load(1, 32'h1003, 1'b0, 1, 32'h80FF1234, 1'b0, 32'h0, 0);
    do_load(2, 32'h1002, 1'b0, 4, 32'h80FF1234, 1'b0, 32'h0, 1);
    do_load(4, 32'h1000, 1'b0, 2, 32'hCAFEF00D, 1'b1, 32'h12345678, 0);
    do_load(2, 32'h1001, 1'b0, 2, 32'h0, 1'b0, 32'h0, 0);
    do_load(4, 32'hF000_0100, 1'b0, 2, 32'h0, 1'b0, 32'h0, 0);
    do_load(4, 32'hF000_0100, 1'b1, 2, 32'h5555AAAA, 1'b0, 32'h0, 0);
    do_load(4, 32'h2000, 1'b1, 0, 32'h0, 1'b0, 32'h0, 4);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[31:28] = 4'hF; else a[31:28] = 4'h1;
      do_load(int'($urandom_range(0, 4)), a, 1'($urandom_range(0, 1)), int'($urandom_range(1, 5)),
              $urandom, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 2)));
    end

    // Flush while waiting on memory: the late response must be ignored.
    valid_op = 1'b1; op_in = 3'd4; addr_in = 32'h3000; priv = 1'b0;
    step();
    valid_op = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_idle", 32'(idle), 32'd1);
    load_valid = 1'b1; load_data = 32'h11112222;
    step();
    load_valid = 1'b0;
    check("flush_dv", 32'(data_valid), 32'd0);
    check("flush_data", loaded_data, 32'd0);
    step();
    check("flush_idle2", 32'(idle), 32'd1);

    // Asynchronous reset while waiting on memory.
    valid_op = 1'b1; op_in = 3'd4; addr_in = 32'h4000;
    step();
    valid_op = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("areset_idle", 32'(idle), 32'd1);
    step();
    rst_n = 1'b1;
    load_valid = 1'b1; load_data = 32'h33334444;
    step();
    load_valid = 1'b0;
    check("areset_dv", 32'(data_valid), 32'd0);
    check("areset_data", loaded_data, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
